// File: rtl/cnn_act_pkg.sv
// Shared definitions for the CNN activation stage: mode encodings and widths.
package cnn_act_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLAMP  = 2'd3
    } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation function: purely combinational f(x, en, mode).
module act_lane
    import cnn_act_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 127
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic                     en,
    input  act_mode_e                mode,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [DATA_W-1:0] CLAMP_V = DATA_W'(CLAMP_MAX);

    logic x_neg;
    logic x_zero;

    // Sign and zero are tested bitwise so no comparison can silently turn unsigned.
    assign x_neg  = x[DATA_W-1];
    assign x_zero = (x == '0);

    // Select the activation result; a disabled lane is forced to zero in every mode.
    always_comb begin
        // NOTE: y gets a default first so no path through the case can infer a latch.
        y = '0;
        if (en) begin
            unique case (mode)
                ACT_BYPASS: y = x;
                ACT_RELU:   y = (x_neg || x_zero) ? '0 : x;
                ACT_LEAKY:  y = x_neg ? (x >>> LEAK_SHIFT) : x;
                ACT_CLAMP:  y = (x_neg || x_zero) ? '0 : ((x > CLAMP_V) ? CLAMP_V : x);
                default:    y = '0;
            endcase
        end
    end

endmodule

// File: rtl/activation_array.sv
// Multi-lane activation stage: two-stage pipeline with valid/ready backpressure,
// per-lane enable masking and a saturating count of zero-valued output lanes.
module activation_array
    import cnn_act_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LANES      = 9,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 127,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MODE_W-1:0]       mode,
    input  logic [LANES-1:0]        lane_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        zero_cnt
);

    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic                    s1_valid_q, s1_valid_d;
    logic [LANES*DATA_W-1:0] s1_data_q,  s1_data_d;
    act_mode_e               s1_mode_q,  s1_mode_d;
    logic [LANES-1:0]        s1_en_q,    s1_en_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [LANES*DATA_W-1:0] s2_data_q,  s2_data_d;
    logic [CNT_W-1:0]        zero_cnt_q, zero_cnt_d;

    logic                    adv;
    logic [LANES*DATA_W-1:0] f_data;
    logic [PC_W-1:0]         zero_pc;
    logic [SUM_W-1:0]        cnt_sum;

    // The whole pipe moves together: stage 2 can take a beat whenever it is empty or draining.
    assign adv       = !s2_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign zero_cnt  = zero_cnt_q;

    // Activation function applied to the beat held in stage 1.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_lane #(
            .DATA_W    (DATA_W),
            .LEAK_SHIFT(LEAK_SHIFT),
            .CLAMP_MAX (CLAMP_MAX)
        ) u_lane (
            .x   (s1_data_q[i*DATA_W +: DATA_W]),
            .en  (s1_en_q[i]),
            .mode(s1_mode_q),
            .y   (f_data[i*DATA_W +: DATA_W])
        );
    end

    // Count zero-valued lanes of the activated beat and form the widened counter sum.
    always_comb begin
        zero_pc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (f_data[i*DATA_W +: DATA_W] == '0) zero_pc = zero_pc + PC_W'(1);
        end
        cnt_sum = SUM_W'(zero_cnt_q) + SUM_W'(zero_pc);
    end

    // Next-state for both pipeline stages and the saturating zero counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_en_d    = s1_en_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        zero_cnt_d = zero_cnt_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_data_d  = in_data;
            s1_mode_d  = act_mode_e'(mode);
            s1_en_d    = lane_en;
            s2_valid_d = s1_valid_q;
            s2_data_d  = f_data;
            if (s1_valid_q) begin
                zero_cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            end
        end
        if (cnt_clr) zero_cnt_d = '0;
    end

    // State registers; reset discards every in-flight beat and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_BYPASS;
            s1_en_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            zero_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_en_q    <= s1_en_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

endmodule

// File: tb/tb_activation_array.sv
// Directed bench for activation_array: vector table for the lane functions plus
// hand-written sequences for backpressure, counter saturation/clear and reset.
module tb_activation_array;

    localparam int DATA_W = 8;
    localparam int LANES  = 9;
    localparam int CNT_W  = 4;
    localparam int DW     = LANES * DATA_W;

    logic            clk;
    logic            rst_n;
    logic [1:0]      mode;
    logic [LANES-1:0] lane_en;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            cnt_clr;
    logic [CNT_W-1:0] zero_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    activation_array #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .LEAK_SHIFT(3),
        .CLAMP_MAX (6),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .lane_en  (lane_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cnt_clr  (cnt_clr),
        .zero_cnt (zero_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string          name;
        logic [1:0]     mode;
        logic [LANES-1:0] en;
        logic [DW-1:0]  d;
        logic [DW-1:0]  e;
        int             zeros;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [DW-1:0] lanes9(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8);
        logic [DW-1:0] r;
        r = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        return r;
    endfunction

    function automatic logic [DW-1:0] bp_beat(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = 8'(k * 10 + i + 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_beat;
    int sent;
    int rcvd;

    initial begin
        vecs[0] = '{"relu",   2'd1, 9'h1FF, lanes9(-5, 0, 7, 127, -128, 1, -1, 2, -2),
                                            lanes9(0, 0, 7, 127, 0, 1, 0, 2, 0), 5};
        vecs[1] = '{"leaky",  2'd2, 9'h1FF, lanes9(-8, -1, -64, 5, 0, -9, 127, -128, -7),
                                            lanes9(-1, -1, -8, 5, 0, -2, 127, -16, -1), 1};
        vecs[2] = '{"clamp",  2'd3, 9'h1FF, lanes9(3, 6, 7, -2, 0, 127, -128, 1, 5),
                                            lanes9(3, 6, 6, 0, 0, 6, 0, 1, 5), 3};
        vecs[3] = '{"mask",   2'd0, 9'h005, lanes9(10, 20, 30, 40, 50, 60, 70, 80, 90),
                                            lanes9(10, 0, 30, 0, 0, 0, 0, 0, 0), 7};
        vecs[4] = '{"bypass", 2'd0, 9'h1FF, lanes9(-128, -1, 0, 1, 127, 5, -5, 0, 9),
                                            lanes9(-128, -1, 0, 1, 127, 5, -5, 0, 9), 2};
        vecs[5] = '{"relu_m", 2'd1, 9'h1F0, lanes9(1, 2, 3, 4, 5, -6, 7, 0, 9),
                                            lanes9(0, 0, 0, 0, 5, 0, 7, 0, 9), 6};

        rst_n     = 1'b0;
        mode      = 2'd0;
        lane_en   = '1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data",  out_data, '0);
        check("rst_zero_cnt",  DW'(zero_cnt), DW'(0));
        check("rst_in_ready",  DW'(in_ready), DW'(1));
        rst_n = 1'b1;
        tick();

        // Table-driven lane-function vectors, one beat each through the pipe.
        for (int v = 0; v < 6; v++) begin
            cnt_clr = 1'b1;
            tick();
            cnt_clr  = 1'b0;
            mode     = vecs[v].mode;
            lane_en  = vecs[v].en;
            in_data  = vecs[v].d;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check({vecs[v].name, "_lat1_valid"}, DW'(out_valid), DW'(0));
            tick();
            check({vecs[v].name, "_valid"}, DW'(out_valid), DW'(1));
            check({vecs[v].name, "_data"},  out_data, vecs[v].e);
            check({vecs[v].name, "_zeros"}, DW'(zero_cnt), DW'(vecs[v].zeros));
        end
        tick();

        // Backpressure: ten-beat stream with out_ready low for four cycles.
        mode    = 2'd0;
        lane_en = '1;
        sent    = 0;
        rcvd    = 0;
        for (int c = 0; c < 60 && rcvd < 10; c++) begin
            out_ready = !(c >= 5 && c < 9);
            in_valid  = (sent < 10);
            in_data   = bp_beat(sent);
            #1;
            if (out_valid && !out_ready) check("bp_in_ready_stall", DW'(in_ready), DW'(0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("bp_unexpected_beat", out_data, '1);
                end else begin
                    exp_beat = q.pop_front();
                    check($sformatf("bp_beat%0d", rcvd), out_data, exp_beat);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(bp_beat(sent));
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", DW'(sent), DW'(10));
        check("bp_rcvd", DW'(rcvd), DW'(10));
        tick();
        tick();
        check("bp_drained", DW'(out_valid), DW'(0));

        // Counter saturation with all-zero beats (9 zero lanes each).
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        mode     = 2'd0;
        lane_en  = '1;
        in_data  = '0;
        in_valid = 1'b1;
        tick();
        tick();
        check("cnt_first", DW'(zero_cnt), DW'(9));
        tick();
        check("cnt_sat", DW'(zero_cnt), DW'(15));
        tick();
        in_valid = 1'b0;
        check("cnt_sat_hold", DW'(zero_cnt), DW'(15));
        tick();
        tick();
        // Clear collides with a zero beat entering stage 2: clear wins.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_beat_valid", DW'(out_valid), DW'(1));
        check("clr_wins", DW'(zero_cnt), DW'(0));
        tick();
        check("clr_hold", DW'(zero_cnt), DW'(0));

        // Asynchronous reset with two beats in flight.
        in_data  = lanes9(0, 0, 0, 1, 1, 1, 1, 1, 1);
        in_valid = 1'b1;
        tick();
        in_data = lanes9(2, 2, 2, 2, 2, 2, 2, 2, 2);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", DW'(out_valid), DW'(1));
        check("pre_rst_cnt",   DW'(zero_cnt), DW'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", DW'(out_valid), DW'(0));
        check("async_rst_cnt",   DW'(zero_cnt), DW'(0));
        check("async_rst_data",  out_data, '0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_flushed", DW'(out_valid), DW'(0));
        in_data  = lanes9(4, 0, 4, 0, 4, 0, 4, 0, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_lat1", DW'(out_valid), DW'(0));
        tick();
        check("post_rst_valid", DW'(out_valid), DW'(1));
        check("post_rst_data",  out_data, lanes9(4, 0, 4, 0, 4, 0, 4, 0, 4));
        check("post_rst_cnt",   DW'(zero_cnt), DW'(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
